// File: rtl/rvga_types.sv
// rvga_types: shared register-index width and scoreboard sizing for the rfetch stage.
package rvga_types;
  localparam int REG_W = 5;
  localparam int SB_DEPTH = 4;
  typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/rfetch_sb_fifo.sv
// rfetch_sb_fifo: in-order FIFO of in-flight destination registers with per-entry valid bits.
module rfetch_sb_fifo
  import rvga_types::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  reg_idx_t                 push_rd,
  input  logic                     pop,
  output reg_idx_t                 ent [DEPTH],
  output logic [DEPTH-1:0]         valid,
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output reg_idx_t                 head_rd,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      valid   <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      count_o <= count_o + CW'(push) - CW'(pop);
    end
  end
  // Storage needs no reset: entries are only observed through their valid bits.
  always_ff @(posedge clk_i) begin
    if (push) ent[wr_ptr] <= push_rd;
  end
  assign head_ptr = rd_ptr;
  assign head_rd  = ent[rd_ptr];
endmodule

// File: rtl/rfetch_scoreboard.sv
// rfetch_scoreboard: tracks in-flight rd writes and stalls rfetch on source hazards or a full table.
module rfetch_scoreboard
  import rvga_types::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  reg_idx_t               rs1_i,
  input  reg_idx_t               rs2_i,
  input  logic [1:0]             rs_v_i,
  input  logic                   issue_v_i,
  input  logic                   issue_rd_w_v_i,
  input  reg_idx_t               issue_rd_i,
  input  logic                   flush_v_i,
  input  logic                   wb_v_i,
  input  reg_idx_t               wb_rd_i,
  output logic                   stall_v_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   wb_err_o
);
  localparam int PW = $clog2(DEPTH);
  reg_idx_t         ent [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head_ptr;
  reg_idx_t         head_rd;
  logic             pop, push, hazard;
  assign pop = wb_v_i && (count_o != '0);
  // The head being retired this cycle is forwarded by the register file, so it cannot hazard.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && !(pop && head_ptr == PW'(i)) &&
          ((rs_v_i[0] && rs1_i != '0 && ent[i] == rs1_i) ||
           (rs_v_i[1] && rs2_i != '0 && ent[i] == rs2_i)))
        hazard = 1'b1;
  end
  assign stall_v_o = hazard | count_o[PW];
  assign push = issue_v_i && issue_rd_w_v_i && (issue_rd_i != '0) && !flush_v_i && !stall_v_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wb_err_o <= 1'b0;
    else if (wb_v_i && (count_o == '0 || wb_rd_i != head_rd)) wb_err_o <= 1'b1;
  end
  rfetch_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push),
    .push_rd  (issue_rd_i),
    .pop      (pop),
    .ent      (ent),
    .valid    (valid),
    .head_ptr (head_ptr),
    .head_rd  (head_rd),
    .count_o  (count_o)
  );
endmodule
